// File: rtl/bioz_adc_capture.sv
// BioZ ADC capture: conversion check, block averaging with Fsel tag, output FIFO.
// Define BIOZ_CAP_MINMAX_EN to add per-block Out_Min/Out_Max.
module bioz_adc_capture #(
   parameter int DATA_W       = 10,
   parameter int AVG_LOG2     = 3,
   parameter int CONV_TIMEOUT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk_ADC,
   input  logic                          Reset,
   input  logic                          ADC_En,
   input  logic                          ADC_Start,
   input  logic                          ADC_Valid,
   input  logic [DATA_W-1:0]             ADC_Data,
   input  logic [3:0]                    Fsel,
   input  logic                          Err_Clr,
   output logic                          Out_Valid,
   input  logic                          Out_Ready,
   output logic [DATA_W-1:0]             Out_Data,
   output logic [3:0]                    Out_Fsel,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
   output logic                          Conv_Err,
   output logic                          Overflow
`ifdef BIOZ_CAP_MINMAX_EN
   ,
   output logic [DATA_W-1:0]             Out_Min,
   output logic [DATA_W-1:0]             Out_Max
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int AW = DATA_W + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam int TW = $clog2(CONV_TIMEOUT + 1);
   localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);
   localparam logic [TW-1:0] TMAX  = TW'(CONV_TIMEOUT);
   localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [3:0]        fsel;
`ifdef BIOZ_CAP_MINMAX_EN
      logic [DATA_W-1:0] mn;
      logic [DATA_W-1:0] mx;
`endif
   } entry_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d, timer_inc;
   logic [AW-1:0]     acc_q, acc_d, acc_b, acc_n;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_b, cnt_n;
   logic [3:0]        tag_q, tag_d, tag_n;
   logic [3:0]        fsel_q;
   logic              conv_err_q, conv_err_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   entry_t            mem_q [FIFO_DEPTH];
   entry_t            entry;
   logic              accept, err_set, clr, first;
   logic              push, pop, wr_ok;
`ifdef BIOZ_CAP_MINMAX_EN
   logic [DATA_W-1:0] min_q, min_d, min_n;
   logic [DATA_W-1:0] max_q, max_d, max_n;
`endif

   assign timer_inc = timer_q + TW'(1);

   // Conversion handshake FSM
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      err_set = 1'b0;
      accept  = 1'b0;
      if (!ADC_En) begin
         state_d = S_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ADC_Start) begin
                  state_d = S_WAIT;
                  timer_d = '0;
               end
            end
            S_WAIT: begin
               if (ADC_Valid) begin
                  accept  = 1'b1;
                  state_d = ADC_Start ? S_WAIT : S_IDLE;
                  timer_d = '0;
               end else if (ADC_Start) begin
                  err_set = 1'b1;
                  timer_d = '0;
               end else if (timer_inc == TMAX) begin
                  err_set = 1'b1;
                  state_d = S_IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Block accumulator; a discard clears the base before a same-cycle sample
   always_comb begin
      clr   = ((Fsel != fsel_q) && (cnt_q != '0)) || !ADC_En;
      acc_b = clr ? '0 : acc_q;
      cnt_b = clr ? '0 : cnt_q;
      first = (cnt_b == '0);
      acc_n = acc_b + AW'(ADC_Data);
      cnt_n = cnt_b + CW'(1);
      tag_n = first ? Fsel : tag_q;
      acc_d = acc_b;
      cnt_d = cnt_b;
      tag_d = tag_q;
      push  = 1'b0;
      entry = '0;
`ifdef BIOZ_CAP_MINMAX_EN
      min_n = (first || ADC_Data < min_q) ? ADC_Data : min_q;
      max_n = (first || ADC_Data > max_q) ? ADC_Data : max_q;
      min_d = min_q;
      max_d = max_q;
`endif
      if (accept) begin
         entry.data = acc_n[AW-1:AVG_LOG2];
         entry.fsel = tag_n;
`ifdef BIOZ_CAP_MINMAX_EN
         entry.mn = min_n;
         entry.mx = max_n;
         min_d    = min_n;
         max_d    = max_n;
`endif
         if (cnt_n == NSAMP) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            tag_d = tag_n;
         end
      end
   end

   // Output FIFO and sticky flags
   always_comb begin
      pop      = (level_q != '0) && Out_Ready;
      wr_ok    = push && ((level_q != FULL) || pop);
      wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (wr_ok && !pop)
         level_d = level_q + LW'(1);
      else if (!wr_ok && pop)
         level_d = level_q - LW'(1);
      conv_err_d = err_set | (conv_err_q & ~Err_Clr);
      ovf_d      = (push & ~wr_ok) | (ovf_q & ~Err_Clr);
   end

   always_ff @(posedge clk_ADC or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         tag_q      <= '0;
         fsel_q     <= '0;
         conv_err_q <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
`ifdef BIOZ_CAP_MINMAX_EN
         min_q <= '0;
         max_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         tag_q      <= tag_d;
         fsel_q     <= Fsel;
         conv_err_q <= conv_err_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         if (wr_ok)
            mem_q[wr_ptr_q] <= entry;
`ifdef BIOZ_CAP_MINMAX_EN
         min_q <= min_d;
         max_q <= max_d;
`endif
      end
   end

   assign Out_Valid  = (level_q != '0);
   assign Out_Data   = mem_q[rd_ptr_q].data;
   assign Out_Fsel   = mem_q[rd_ptr_q].fsel;
   assign Fifo_Level = level_q;
   assign Conv_Err   = conv_err_q;
   assign Overflow   = ovf_q;
`ifdef BIOZ_CAP_MINMAX_EN
   assign Out_Min = mem_q[rd_ptr_q].mn;
   assign Out_Max = mem_q[rd_ptr_q].mx;
`endif

endmodule

// File: tb/tb_bioz_adc_capture.sv
// Directed bench for bioz_adc_capture.
// Define BIOZ_CAP_MINMAX_EN to also exercise Out_Min/Out_Max.
module tb_bioz_adc_capture;

   logic       clk_ADC = 1'b0;
   logic       Reset = 1'b1;
   logic       ADC_En = 1'b0;
   logic       ADC_Start = 1'b0;
   logic       ADC_Valid = 1'b0;
   logic [9:0] ADC_Data = '0;
   logic [3:0] Fsel = '0;
   logic       Err_Clr = 1'b0;
   logic       Out_Valid;
   logic       Out_Ready = 1'b0;
   logic [9:0] Out_Data;
   logic [3:0] Out_Fsel;
   logic [2:0] Fifo_Level;
   logic       Conv_Err;
   logic       Overflow;
`ifdef BIOZ_CAP_MINMAX_EN
   logic [9:0] Out_Min;
   logic [9:0] Out_Max;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_ADC = ~clk_ADC;

   bioz_adc_capture dut (
      .clk_ADC(clk_ADC), .Reset(Reset), .ADC_En(ADC_En),
      .ADC_Start(ADC_Start), .ADC_Valid(ADC_Valid),
      .ADC_Data(ADC_Data), .Fsel(Fsel), .Err_Clr(Err_Clr),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Data(Out_Data), .Out_Fsel(Out_Fsel),
      .Fifo_Level(Fifo_Level), .Conv_Err(Conv_Err),
      .Overflow(Overflow)
`ifdef BIOZ_CAP_MINMAX_EN
      , .Out_Min(Out_Min), .Out_Max(Out_Max)
`endif
   );

   // One 15-cycle conversion: Start, two idle cycles, Valid with data/fsel
   task automatic do_conv(input logic [9:0] d, input logic [3:0] f);
      @(negedge clk_ADC) ADC_Start = 1'b1;
      @(negedge clk_ADC) ADC_Start = 1'b0;
      repeat (2) @(negedge clk_ADC);
      ADC_Valid = 1'b1;
      ADC_Data  = d;
      Fsel      = f;
      @(negedge clk_ADC) ADC_Valid = 1'b0;
      repeat (10) @(negedge clk_ADC);
   endtask

   task automatic pop_one();
      @(negedge clk_ADC) Out_Ready = 1'b1;
      @(negedge clk_ADC) Out_Ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_ADC);
      #1;
      n_cmp += 6;
      if (Out_Valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_valid got %0b want 0", Out_Valid);
      end
      if (Fifo_Level !== 3'd0) begin
         n_bad++; $display("FAIL rst_level got %0d want 0", Fifo_Level);
      end
      if (Conv_Err !== 1'b0) begin
         n_bad++; $display("FAIL rst_err got %0b want 0", Conv_Err);
      end
      if (Overflow !== 1'b0) begin
         n_bad++; $display("FAIL rst_ovf got %0b want 0", Overflow);
      end
      if (Out_Data !== 10'd0) begin
         n_bad++; $display("FAIL rst_data got %0d want 0", Out_Data);
      end
      if (Out_Fsel !== 4'd0) begin
         n_bad++; $display("FAIL rst_fsel got %0d want 0", Out_Fsel);
      end
      @(negedge clk_ADC) Reset = 1'b0;
      ADC_En = 1'b1;
      Fsel   = 4'd10;
      repeat (2) @(negedge clk_ADC);
   endtask

   task automatic test_average();
      for (int i = 0; i < 7; i++)
         do_conv(10'(100 + i), 4'd10);
      @(negedge clk_ADC) ADC_Start = 1'b1;
      @(negedge clk_ADC) ADC_Start = 1'b0;
      repeat (2) @(negedge clk_ADC);
      ADC_Valid = 1'b1;
      ADC_Data  = 10'd107;
      #1;
      n_cmp++;
      if (Out_Valid !== 1'b0) begin
         n_bad++; $display("FAIL avg_early got %0b want 0", Out_Valid);
      end
      @(posedge clk_ADC);
      #1;
      n_cmp += 4;
      if (Out_Valid !== 1'b1) begin
         n_bad++; $display("FAIL avg_valid got %0b want 1", Out_Valid);
      end
      if (Out_Data !== 10'd103) begin
         n_bad++; $display("FAIL avg_data got %0d want 103", Out_Data);
      end
      if (Out_Fsel !== 4'd10) begin
         n_bad++; $display("FAIL avg_fsel got %0d want 10", Out_Fsel);
      end
      if (Fifo_Level !== 3'd1) begin
         n_bad++; $display("FAIL avg_level got %0d want 1", Fifo_Level);
      end
      @(negedge clk_ADC) ADC_Valid = 1'b0;
      pop_one();
      n_cmp++;
      if (Out_Valid !== 1'b0) begin
         n_bad++; $display("FAIL avg_pop got %0b want 0", Out_Valid);
      end
   endtask

   task automatic test_timeout();
      @(negedge clk_ADC) ADC_Start = 1'b1;
      @(posedge clk_ADC);
      @(negedge clk_ADC) ADC_Start = 1'b0;
      repeat (15) @(posedge clk_ADC);
      #1;
      n_cmp++;
      if (Conv_Err !== 1'b0) begin
         n_bad++; $display("FAIL to_edge15 got %0b want 0", Conv_Err);
      end
      @(posedge clk_ADC);
      #1;
      n_cmp += 2;
      if (Conv_Err !== 1'b1) begin
         n_bad++; $display("FAIL to_edge16 got %0b want 1", Conv_Err);
      end
      if (Fifo_Level !== 3'd0) begin
         n_bad++; $display("FAIL to_level got %0d want 0", Fifo_Level);
      end
      @(negedge clk_ADC) Err_Clr = 1'b1;
      @(negedge clk_ADC) Err_Clr = 1'b0;
      n_cmp++;
      if (Conv_Err !== 1'b0) begin
         n_bad++; $display("FAIL to_clr got %0b want 0", Conv_Err);
      end
      // Second Start inside WAIT, then complete and abort via ADC_En
      @(negedge clk_ADC) ADC_Start = 1'b1;
      @(negedge clk_ADC) ADC_Start = 1'b0;
      repeat (2) @(negedge clk_ADC);
      ADC_Start = 1'b1;
      @(posedge clk_ADC);
      #1;
      n_cmp++;
      if (Conv_Err !== 1'b1) begin
         n_bad++; $display("FAIL restart_err got %0b want 1", Conv_Err);
      end
      @(negedge clk_ADC) ADC_Start = 1'b0;
      ADC_Valid = 1'b1;
      ADC_Data  = 10'd500;
      @(negedge clk_ADC) ADC_Valid = 1'b0;
      ADC_En  = 1'b0;
      Err_Clr = 1'b1;
      @(negedge clk_ADC) ADC_En = 1'b1;
      Err_Clr = 1'b0;
      for (int i = 0; i < 8; i++)
         do_conv(10'd20, 4'd10);
      n_cmp += 3;
      if (Fifo_Level !== 3'd1) begin
         n_bad++; $display("FAIL abort_level got %0d want 1", Fifo_Level);
      end
      if (Out_Data !== 10'd20) begin
         n_bad++; $display("FAIL abort_data got %0d want 20", Out_Data);
      end
      if (Conv_Err !== 1'b0) begin
         n_bad++; $display("FAIL abort_err got %0b want 0", Conv_Err);
      end
      pop_one();
   endtask

   task automatic test_fsel_change();
      for (int i = 0; i < 5; i++)
         do_conv(10'd200, 4'd10);
      @(negedge clk_ADC) Fsel = 4'd9;
      repeat (2) @(negedge clk_ADC);
      for (int i = 0; i < 8; i++)
         do_conv(10'd50, 4'd9);
      n_cmp += 3;
      if (Fifo_Level !== 3'd1) begin
         n_bad++; $display("FAIL fsel_level got %0d want 1", Fifo_Level);
      end
      if (Out_Data !== 10'd50) begin
         n_bad++; $display("FAIL fsel_data got %0d want 50", Out_Data);
      end
      if (Out_Fsel !== 4'd9) begin
         n_bad++; $display("FAIL fsel_tag got %0d want 9", Out_Fsel);
      end
      pop_one();
      // Fsel change coincident with an accepted sample
      for (int i = 0; i < 3; i++)
         do_conv(10'd50, 4'd9);
      for (int i = 0; i < 8; i++)
         do_conv(10'd80, 4'd4);
      n_cmp += 3;
      if (Fifo_Level !== 3'd1) begin
         n_bad++; $display("FAIL same_level got %0d want 1", Fifo_Level);
      end
      if (Out_Data !== 10'd80) begin
         n_bad++; $display("FAIL same_data got %0d want 80", Out_Data);
      end
      if (Out_Fsel !== 4'd4) begin
         n_bad++; $display("FAIL same_tag got %0d want 4", Out_Fsel);
      end
      pop_one();
   endtask

   task automatic test_overflow();
      for (int b = 0; b < 5; b++) begin
         if (b == 4) begin
            n_cmp++;
            if (Overflow !== 1'b0) begin
               n_bad++; $display("FAIL ovf_early got %0b want 0", Overflow);
            end
         end
         for (int i = 0; i < 8; i++)
            do_conv(10'((b + 1) * 10), 4'd3);
      end
      n_cmp += 2;
      if (Fifo_Level !== 3'd4) begin
         n_bad++; $display("FAIL ovf_level got %0d want 4", Fifo_Level);
      end
      if (Overflow !== 1'b1) begin
         n_bad++; $display("FAIL ovf_flag got %0b want 1", Overflow);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp += 2;
         if (Out_Data !== 10'((i + 1) * 10)) begin
            n_bad++;
            $display("FAIL ovf_pop%0d got %0d want %0d", i, Out_Data, (i + 1) * 10);
         end
         if (Out_Fsel !== 4'd3) begin
            n_bad++; $display("FAIL ovf_tag%0d got %0d want 3", i, Out_Fsel);
         end
         pop_one();
      end
      n_cmp++;
      if (Out_Valid !== 1'b0) begin
         n_bad++; $display("FAIL ovf_empty got %0b want 0", Out_Valid);
      end
      @(negedge clk_ADC) Err_Clr = 1'b1;
      @(negedge clk_ADC) Err_Clr = 1'b0;
      n_cmp++;
      if (Overflow !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clr got %0b want 0", Overflow);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++)
         do_conv(10'd30, 4'd2);
      for (int i = 0; i < 3; i++)
         do_conv(10'd99, 4'd2);
      @(negedge clk_ADC) ADC_Start = 1'b1;
      @(negedge clk_ADC) ADC_Start = 1'b0;
      Reset = 1'b1;
      @(negedge clk_ADC) Reset = 1'b0;
      n_cmp++;
      if (Fifo_Level !== 3'd0) begin
         n_bad++; $display("FAIL rmid_level got %0d want 0", Fifo_Level);
      end
      for (int i = 0; i < 8; i++)
         do_conv(10'd7, 4'd2);
      n_cmp += 3;
      if (Fifo_Level !== 3'd1) begin
         n_bad++; $display("FAIL rmid_level2 got %0d want 1", Fifo_Level);
      end
      if (Out_Data !== 10'd7) begin
         n_bad++; $display("FAIL rmid_data got %0d want 7", Out_Data);
      end
      if (Out_Fsel !== 4'd2) begin
         n_bad++; $display("FAIL rmid_tag got %0d want 2", Out_Fsel);
      end
      pop_one();
   endtask

`ifdef BIOZ_CAP_MINMAX_EN
   task automatic test_minmax();
      logic [9:0] vals [8];
      vals = '{10'd5, 10'd900, 10'd12, 10'd300, 10'd0, 10'd44, 10'd8, 10'd1};
      for (int i = 0; i < 8; i++)
         do_conv(vals[i], 4'd6);
      n_cmp += 3;
      if (Out_Min !== 10'd0) begin
         n_bad++; $display("FAIL mm_min got %0d want 0", Out_Min);
      end
      if (Out_Max !== 10'd900) begin
         n_bad++; $display("FAIL mm_max got %0d want 900", Out_Max);
      end
      if (Out_Data !== 10'd158) begin
         n_bad++; $display("FAIL mm_data got %0d want 158", Out_Data);
      end
      pop_one();
   endtask
`endif

   initial begin
      test_reset();
      test_average();
      test_timeout();
      test_fsel_change();
      test_overflow();
      test_reset_mid();
`ifdef BIOZ_CAP_MINMAX_EN
      test_minmax();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
